// File: rtl/smc_pkg.sv
// Shared types and constants for the Super MOSFET Calculator front end.
// Also holds the per-transistor Id/gm evaluation used by the calculator.
package smc_pkg;

  localparam int unsigned NUM_TR   = 6;
  localparam int unsigned FIELD_W  = 3;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned VAL_W    = 7;
  localparam int unsigned PROD_W   = 10;
  localparam int unsigned OUT_W    = 8;
  localparam int unsigned MODE_W   = 2;
  localparam int unsigned MODE_ID  = 0;
  localparam int unsigned MODE_MAX = 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    OUT     = 2'd2
  } state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] w;
    logic [FIELD_W-1:0] v_gs;
    logic [FIELD_W-1:0] v_ds;
  } tr_param_t;

  // Overdrive V_GS-1 floors at 0 so V_GS=0 behaves as cut-off rather than wrapping.
  function automatic logic [VAL_W-1:0] tr_value(input tr_param_t p, input logic sel_id);
    logic [FIELD_W-1:0] ov;
    logic [PROD_W-1:0]  prod;
    ov = (p.v_gs == '0) ? '0 : p.v_gs - FIELD_W'(1);
    if (sel_id) begin
      if (ov > p.v_ds)
        prod = PROD_W'(p.w) * PROD_W'(p.v_ds) * (PROD_W'(ov) * PROD_W'(2) - PROD_W'(p.v_ds));
      else
        prod = PROD_W'(p.w) * PROD_W'(ov) * PROD_W'(ov);
    end else begin
      if (ov > p.v_ds)
        prod = PROD_W'(2) * PROD_W'(p.w) * PROD_W'(p.v_ds);
      else
        prod = PROD_W'(2) * PROD_W'(p.w) * PROD_W'(ov);
    end
    return VAL_W'(prod / PROD_W'(3));
  endfunction

endpackage

// File: rtl/smc_frontend_smc.sv
// Combinational Super MOSFET Calculator: per-transistor Id/gm, pick the
// largest or smallest three, and reduce them to one 8-bit figure.
module SMC
  import smc_pkg::*;
(
  input  logic [MODE_W-1:0]  mode,
  input  logic [FIELD_W-1:0] W_0, V_GS_0, V_DS_0,
  input  logic [FIELD_W-1:0] W_1, V_GS_1, V_DS_1,
  input  logic [FIELD_W-1:0] W_2, V_GS_2, V_DS_2,
  input  logic [FIELD_W-1:0] W_3, V_GS_3, V_DS_3,
  input  logic [FIELD_W-1:0] W_4, V_GS_4, V_DS_4,
  input  logic [FIELD_W-1:0] W_5, V_GS_5, V_DS_5,
  output logic [OUT_W-1:0]   out_n
);

  tr_param_t          p   [NUM_TR];
  logic [VAL_W-1:0]   val [NUM_TR];
  logic [VAL_W-1:0]   srt [NUM_TR];
  logic [VAL_W-1:0]   a, b, c;
  logic [PROD_W-1:0]  res;

  assign p[0] = tr_param_t'({W_0, V_GS_0, V_DS_0});
  assign p[1] = tr_param_t'({W_1, V_GS_1, V_DS_1});
  assign p[2] = tr_param_t'({W_2, V_GS_2, V_DS_2});
  assign p[3] = tr_param_t'({W_3, V_GS_3, V_DS_3});
  assign p[4] = tr_param_t'({W_4, V_GS_4, V_DS_4});
  assign p[5] = tr_param_t'({W_5, V_GS_5, V_DS_5});

  always_comb begin
    for (int i = 0; i < NUM_TR; i++) val[i] = tr_value(p[i], mode[MODE_ID]);
  end

  // Descending sort by rank; ties broken by index so every slot gets exactly one value.
  always_comb begin
    int unsigned rank;
    for (int i = 0; i < NUM_TR; i++) srt[i] = '0;
    for (int i = 0; i < NUM_TR; i++) begin
      rank = 0;
      for (int j = 0; j < NUM_TR; j++) begin
        if ((val[j] > val[i]) || ((val[j] == val[i]) && (j < i))) rank = rank + 1;
      end
      srt[rank] = val[i];
    end
  end

  always_comb begin
    if (mode[MODE_MAX]) begin
      a = srt[0];
      b = srt[1];
      c = srt[2];
    end else begin
      a = srt[3];
      b = srt[4];
      c = srt[5];
    end
    if (mode[MODE_ID])
      res = (PROD_W'(a) * PROD_W'(3) + PROD_W'(b) * PROD_W'(4) + PROD_W'(c) * PROD_W'(5))
            / PROD_W'(12);
    else
      res = (PROD_W'(a) + PROD_W'(b) + PROD_W'(c)) / PROD_W'(3);
    out_n = OUT_W'(res);
  end

endmodule

// File: rtl/smc_frontend.sv
// Serial valid/ready front end for SMC: collects six parameter beats into a
// slot bank, evaluates from registered operands, returns a one-cycle result.
module smc_frontend
  import smc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MODE_W-1:0]  mode,
  input  logic [FIELD_W-1:0] W,
  input  logic [FIELD_W-1:0] V_GS,
  input  logic [FIELD_W-1:0] V_DS,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_n
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0]    out_n_q, out_n_d;
  logic [MODE_W-1:0]   mode_q;
  tr_param_t           slot_q [NUM_TR];
  logic [OUT_W-1:0]    calc_n;
  logic                accept;
  logic                last_beat;

  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt_q == CNT_W'(NUM_TR - 1));
  assign out_n     = out_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && last_beat) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result is captured leaving CALC and cleared leaving OUT.
  always_comb begin
    cnt_d   = cnt_q;
    out_n_d = '0;
    if (accept) cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    if (state_q == CALC) out_n_d = calc_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      out_n_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      out_n_q <= out_n_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TR; i++) slot_q[i] <= '0;
      mode_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_TR; i++) begin
        if (cnt_q == CNT_W'(i)) slot_q[i] <= tr_param_t'({W, V_GS, V_DS});
      end
      if (cnt_q == '0) mode_q <= mode;
    end
  end

  SMC u_smc (
    .mode   (mode_q),
    .W_0    (slot_q[0].w), .V_GS_0 (slot_q[0].v_gs), .V_DS_0 (slot_q[0].v_ds),
    .W_1    (slot_q[1].w), .V_GS_1 (slot_q[1].v_gs), .V_DS_1 (slot_q[1].v_ds),
    .W_2    (slot_q[2].w), .V_GS_2 (slot_q[2].v_gs), .V_DS_2 (slot_q[2].v_ds),
    .W_3    (slot_q[3].w), .V_GS_3 (slot_q[3].v_gs), .V_DS_3 (slot_q[3].v_ds),
    .W_4    (slot_q[4].w), .V_GS_4 (slot_q[4].v_gs), .V_DS_4 (slot_q[4].v_ds),
    .W_5    (slot_q[5].w), .V_GS_5 (slot_q[5].v_gs), .V_DS_5 (slot_q[5].v_ds),
    .out_n  (calc_n)
  );

endmodule

// File: tb/tb_smc_frontend.sv
// Self-checking bench for smc_frontend: directed cases plus random sets
// compared against a sort-and-average reference model.
module tb_smc_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [2:0] W, V_GS, V_DS;
  logic       out_valid;
  logic [7:0] out_n;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int idle_bad = 0;
  int pulse_n[$];
  int pulse_c[$];

  int sw[6], svgs[6], svds[6];

  smc_frontend dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      pulse_n.push_back(int'(out_n));
      pulse_c.push_back(cyc);
    end else if (out_n != 8'd0) begin
      idle_bad++;
    end
  end

  // Reference: evaluate each transistor, sort descending, average the chosen three.
  function automatic int model(input int m);
    int v[6];
    int ov, t, a, b, c;
    for (int i = 0; i < 6; i++) begin
      ov = (svgs[i] > 0) ? svgs[i] - 1 : 0;
      if (m % 2 == 1) v[i] = (ov > svds[i]) ? sw[i] * svds[i] * (2 * ov - svds[i]) : sw[i] * ov * ov;
      else            v[i] = (ov > svds[i]) ? 2 * sw[i] * svds[i] : 2 * sw[i] * ov;
      v[i] = v[i] / 3;
    end
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5 - i; j++)
        if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    if (m >= 2) begin a = v[0]; b = v[1]; c = v[2]; end
    else        begin a = v[3]; b = v[4]; c = v[5]; end
    return (m % 2 == 1) ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
  endfunction

  task automatic rand_set();
    for (int i = 0; i < 6; i++) begin
      sw[i]   = int'($urandom_range(7, 0));
      svgs[i] = int'($urandom_range(7, 0));
      svds[i] = int'($urandom_range(7, 0));
    end
  endtask

  // Sends beats 0..nbeats-1 from the stimulus arrays; returns the cycle stamp of the last accept.
  task automatic send_set(input int nbeats, input int m0, input int mrest, input int max_gap,
                          input bit hold, output int acc_cyc);
    int g, bnd;
    acc_cyc = 0;
    for (int k = 0; k < nbeats; k++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int t = 0; t < g; t++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      W    = 3'(sw[k]);
      V_GS = 3'(svgs[k]);
      V_DS = 3'(svds[k]);
      mode = (k == 0) ? 2'(m0) : 2'(mrest);
      bnd  = 0;
      @(negedge clk);
      while (!in_ready && bnd < 40) begin
        bnd++;
        @(negedge clk);
      end
      if (bnd >= 40) begin
        n_checks++;
        $display("FAIL beat_timeout: beat %0d in_ready stayed %0b, required 1", k, in_ready);
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
    end
    if (hold) begin
      W = 3'($urandom_range(7, 0)); V_GS = 3'($urandom_range(7, 0)); V_DS = 3'($urandom_range(7, 0));
      mode = 2'($urandom_range(3, 0));
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_pulse(input string name, input int exp, input int acc_cyc);
    int bnd, got, pc;
    bnd = 0;
    while (pulse_n.size() == 0 && bnd < 20) begin
      bnd++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (pulse_n.size() == 0) begin
      $display("FAIL %s_pulse: no out_valid seen, required one", name);
      return;
    end
    n_pass++;
    got = pulse_n.pop_front();
    pc  = pulse_c.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL %s_value: out_n=%0d, required %0d", name, got, exp);
    else n_pass++;
    n_checks++;
    if (pc - acc_cyc !== 2) $display("FAIL %s_latency: %0d cycles, required 2", name, pc - acc_cyc);
    else n_pass++;
  endtask

  task automatic check_outputs_idle(input string name);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %0b, required 1", name, in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_out_valid: got %0b, required 0", name, out_valid);
    else n_pass++;
    n_checks++;
    if (out_n !== 8'd0) $display("FAIL %s_out_n: got %0d, required 0", name, out_n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mode = 2'd0; W = 3'd0; V_GS = 3'd0; V_DS = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dominant();
    int ac;
    for (int i = 0; i < 6; i++) begin sw[i] = 0; svgs[i] = 0; svds[i] = 0; end
    sw[0] = 7; svgs[0] = 7; svds[0] = 7;
    send_set(6, 3, 0, 0, 1'b0, ac); wait_pulse("dom_id_max", 21, ac);
    n_checks++;
    repeat (3) @(posedge clk); #1;
    if (pulse_n.size() != 0) $display("FAIL dom_single_pulse: %0d extra pulses, required 0", pulse_n.size());
    else n_pass++;
    send_set(6, 2, 0, 0, 1'b0, ac); wait_pulse("dom_gm_max", 9, ac);
    send_set(6, 0, 0, 0, 1'b0, ac); wait_pulse("dom_gm_min", 0, ac);
  endtask

  task automatic test_triode();
    int ac;
    for (int i = 0; i < 6; i++) begin sw[i] = 1; svgs[i] = 7; svds[i] = 1; end
    send_set(6, 1, 1, 0, 1'b0, ac); wait_pulse("triode", 3, ac);
    send_set(6, 1, 2, 0, 1'b0, ac); wait_pulse("triode_mode_ignored", 3, ac);
  endtask

  task automatic test_gapped();
    int ac, m, exp;
    for (int r = 0; r < 3; r++) begin
      rand_set();
      m   = int'($urandom_range(3, 0));
      exp = model(m);
      send_set(6, m, int'($urandom_range(3, 0)), 0, 1'b0, ac); wait_pulse("gapless", exp, ac);
      send_set(6, m, int'($urandom_range(3, 0)), 3, 1'b1, ac); wait_pulse("gapped", exp, ac);
      in_valid = 1'b0;
    end
    rand_set();
    m = int'($urandom_range(3, 0));
    send_set(6, m, 0, 0, 1'b0, ac); wait_pulse("after_gapped", model(m), ac);
  endtask

  task automatic test_reset_mid();
    int ac, m;
    for (int i = 0; i < 6; i++) begin sw[i] = 7; svgs[i] = 7; svds[i] = i; end
    send_set(3, 3, 3, 0, 1'b0, ac);
    #2 rst = 1'b1;
    #1 check_outputs_idle("rst_collect");
    @(posedge clk); #1 rst = 1'b0;
    rand_set();
    m = int'($urandom_range(3, 0));
    send_set(6, m, 0, 0, 1'b0, ac); wait_pulse("after_rst", model(m), ac);
    send_set(6, 3, 0, 0, 1'b0, ac);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    n_checks++;
    if (pulse_n.size() != 0) $display("FAIL rst_calc_drop: %0d pulses, required 0", pulse_n.size());
    else n_pass++;
    pulse_n.delete(); pulse_c.delete();
  endtask

  task automatic test_back_to_back();
    int exp_q[$], acc_q[$];
    int ac, m, bnd;
    pulse_n.delete(); pulse_c.delete();
    for (int s = 0; s < 20; s++) begin
      rand_set();
      m = int'($urandom_range(3, 0));
      exp_q.push_back(model(m));
      send_set(6, m, int'($urandom_range(3, 0)), 0, 1'b1, ac);
      acc_q.push_back(ac);
    end
    in_valid = 1'b1;
    bnd = 0;
    while (pulse_n.size() < 20 && bnd < 40) begin bnd++; @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_checks++;
    if (pulse_n.size() != 20) $display("FAIL b2b_count: %0d pulses, required 20", pulse_n.size());
    else n_pass++;
    for (int i = 0; i < 20 && i < pulse_n.size(); i++) begin
      n_checks++;
      if (pulse_n[i] !== exp_q[i]) $display("FAIL b2b_value[%0d]: out_n=%0d, required %0d", i, pulse_n[i], exp_q[i]);
      else n_pass++;
      n_checks++;
      if (pulse_c[i] - acc_q[i] !== 2) $display("FAIL b2b_latency[%0d]: %0d, required 2", i, pulse_c[i] - acc_q[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (pulse_c[i] - pulse_c[i-1] !== 8) $display("FAIL b2b_spacing[%0d]: %0d, required 8", i, pulse_c[i] - pulse_c[i-1]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_dominant();
    test_triode();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (idle_bad != 0) $display("FAIL idle_out_n: %0d cycles nonzero out_n without out_valid, required 0", idle_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smc_frontend.md
# smc_frontend

Sequential front end for the combinational Super MOSFET Calculator. It accepts the six transistor parameter sets serially, one per beat, over a valid/ready handshake, and holds them in a register bank. It then drives the calculator from registered operands and returns the 8-bit result through a registered, single-cycle `out_valid` pulse. It sits between the pattern/host interface and the calculator, so the calculator's combinational path is isolated between flops on both sides.

## Interface
- Parameters: none; beat count fixed at 6, field widths fixed at 3 bits.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `mode`  in  2  bit0 = 1 selects Id, 0 selects gm; bit1 = 1 selects largest three, 0 selects smallest three. Sampled on beat 0 only.
- `W`, `V_GS`, `V_DS`  in  3 each  parameters for transistor index = beat number (0..5).
- `out_valid`  out  1  one-cycle result strobe.
- `out_n`  out  8  result; 0 whenever `out_valid` = 0.

## Operation
- **Reset state:** state COLLECT, beat counter 0, slot bank 0, mode register 0, `in_ready` = 1, `out_valid` = 0, `out_n` = 0.
- **Handshake:** a beat is accepted on a rising edge where `in_valid & in_ready`.
  - Beat k is written to slot k and the counter increments.
  - Beat 0 also latches `mode`. `mode` on beats 1..5 is ignored.
  - `in_valid` gaps are legal; the counter holds across them.
  - `in_valid` while `in_ready` = 0 is ignored, and nothing is stored.
- **FSM:**
  - COLLECT → CALC when beat 5 is accepted. The counter wraps 5 → 0 on that edge.
  - CALC → OUT unconditionally. During CALC the calculator sees slot registers plus the mode register. `out_n_reg` captures its output on the CALC→OUT edge.
  - OUT → COLLECT unconditionally.
- **Outputs by state:**
  - `in_ready` = 1 only in COLLECT.
  - `out_valid` = 1 only in OUT.
- **Arithmetic:** done entirely in the calculator, with its truncating divisions.
  - Per-transistor Id = W·(V_GS−1)² or W·V_DS·(2(V_GS−1)−V_DS), then ÷3.
  - Per-transistor gm = 2W(V_GS−1) or 2W·V_DS, then ÷3.
  - The triode branch applies when V_GS−1 > V_DS.
  - Id mode: (3a+4b+5c)/12. gm mode: (a+b+c)/3.
  - This block adds no arithmetic and no width changes; `out_n` is the calculator's 8-bit output unchanged.
- **Reset mid-operation:** asserting `rst` in any state aborts immediately.
  - A partial set is discarded and a pending result is dropped.
  - No `out_valid` is issued for the aborted set.

## Timing
- **Latency:** beat 5 accepted at edge E; CALC during cycle E..E+1; `out_valid` high during cycle E+1..E+2; `in_ready` returns high at edge E+2.
- **Throughput:** minimum 8 cycles per set (6 COLLECT + CALC + OUT).
- **Result stability:** `out_n` is registered and is stable for the whole `out_valid` cycle. It is forced to 0 on the OUT→COLLECT edge.
- **Combinational paths:** no combinational path from any input to any output. `in_ready` and `out_valid` decode from the state register only.

## Structure
- **Shared package `smc_pkg`:**
  - `NUM_TR` = 6 and `FIELD_W` = 3.
  - State enum {COLLECT, CALC, OUT}.
  - Packed `tr_param_t` {W, V_GS, V_DS}.
  - Mode bit positions `MODE_ID` = 0 and `MODE_MAX` = 1.
- **Submodule:** exactly one, the existing combinational `SMC`, instantiated with its 18 parameter inputs tied to the slot bank.
- **Local logic:** the counter, slot bank and FSM stay local; no other submodule.

## Test plan
- **Single-dominant set, Id/largest:** beat 0 = {W=7, V_GS=7, V_DS=7}, beats 1–5 all 0, `mode` = 3 on beat 0 → `out_valid` one cycle, 2 cycles after the beat-5 accept edge, `out_n` = 21.
- **Same set, `mode` = 2 (gm/largest):** expect `out_n` = 9. Resend with `mode` = 0 → `out_n` = 0.
- **Triode, Id/smallest:** six beats {W=1, V_GS=7, V_DS=1}, `mode` = 1 → `out_n` = 3. Drive `mode` = 2 on beats 1–5 → result is unchanged.
- **Gapped handshake:** insert 0–3 idle cycles between beats, and hold `in_valid` = 1 during CALC/OUT → extra beats are dropped, the result matches the gapless run, and the next set starts cleanly at slot 0.
- **Reset mid-collect:** assert `rst` after 3 beats → `in_ready` = 1, `out_valid` = 0, `out_n` = 0 immediately. A following full set yields the correct result, with no stale slots.
- **Back-to-back sets:** 20 random sets, with `in_valid` held high throughout → exactly 20 `out_valid` pulses spaced 8 cycles apart, each matching the golden model.
